// File: rtl/nios_debug_scan_master.sv
// Virtual-JTAG scan initiator: one IR load plus one DR_WIDTH-bit DR exchange per command.
// Latency: response valid 1 + 2*TCK_DIV*(3 + DR_WIDTH + RTI_CYCLES) cycles after accept.
// Backpressure: a single command in flight; the response is held until rsp_ready, then idle.
module nios_debug_scan_master #(
    parameter int DR_WIDTH   = 38,
    parameter int IR_WIDTH   = 2,
    parameter int TCK_DIV    = 2,
    parameter int RTI_CYCLES = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [IR_WIDTH-1:0] cmd_ir,
    input  logic [DR_WIDTH-1:0] cmd_data,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DR_WIDTH-1:0] rsp_data,
    output logic                vji_tck,
    output logic                vji_tdi,
    input  logic                vji_tdo,
    output logic [IR_WIDTH-1:0] vji_ir_in,
    output logic                vji_uir,
    output logic                vji_cdr,
    output logic                vji_sdr,
    output logic                vji_udr,
    output logic                vji_rti
);

    localparam int CNT_MAX = (DR_WIDTH > RTI_CYCLES) ? DR_WIDTH : RTI_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam int PW      = (TCK_DIV > 1) ? $clog2(TCK_DIV) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_UIR, S_CDR, S_SDR, S_UDR, S_RTI, S_RSP
    } state_t;

    state_t              state, state_nxt;
    logic [PW-1:0]       phase;
    logic [CW-1:0]       period_cnt;
    logic [DR_WIDTH-1:0] sr_out;
    logic [DR_WIDTH-1:0] capture;
    logic                in_scan, phase_end, tck_rise, tck_fall, last_period, accept;

    assign in_scan   = (state != S_IDLE) && (state != S_RSP);
    assign phase_end = (phase == PW'(TCK_DIV - 1));
    assign tck_rise  = in_scan && phase_end && !vji_tck;
    assign tck_fall  = in_scan && phase_end && vji_tck;
    assign accept    = (state == S_IDLE) && cmd_valid && !reset;

    always_comb begin
        last_period = 1'b1;
        case (state)
            S_SDR:   last_period = (period_cnt == CW'(DR_WIDTH - 1));
            S_RTI:   last_period = (period_cnt == CW'(RTI_CYCLES - 1));
            default: last_period = 1'b1;
        endcase
    end

    // State advances only on the clk edge that drops tck, so the slave never sees a strobe change at a rise.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (cmd_valid) state_nxt = S_UIR;
            S_UIR:   if (tck_fall) state_nxt = S_CDR;
            S_CDR:   if (tck_fall) state_nxt = S_SDR;
            S_SDR:   if (tck_fall && last_period) state_nxt = S_UDR;
            S_UDR:   if (tck_fall) state_nxt = S_RTI;
            S_RTI:   if (tck_fall && last_period) state_nxt = S_RSP;
            S_RSP:   if (rsp_ready) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            phase      <= '0;
            vji_tck    <= 1'b0;
            period_cnt <= '0;
            sr_out     <= '0;
            capture    <= '0;
            vji_ir_in  <= '0;
        end else begin
            if (in_scan) begin
                if (phase_end) begin
                    phase   <= '0;
                    vji_tck <= !vji_tck;
                end else begin
                    phase <= phase + PW'(1);
                end
            end else begin
                phase   <= '0;
                vji_tck <= 1'b0;
            end

            if (tck_fall)
                period_cnt <= last_period ? '0 : period_cnt + CW'(1);

            if (accept) begin
                vji_ir_in  <= cmd_ir;
                sr_out     <= cmd_data;
                capture    <= '0;
                period_cnt <= '0;
            end

            // tdo is taken on the edge that raises tck, before the slave reacts to that rise.
            if (state == S_SDR) begin
                if (tck_rise) capture <= {vji_tdo, capture[DR_WIDTH-1:1]};
                if (tck_fall) sr_out  <= sr_out >> 1;
            end
        end
    end

    assign cmd_ready = (state == S_IDLE) && !reset;
    assign rsp_valid = (state == S_RSP);
    assign rsp_data  = capture;
    assign vji_tdi   = (state == S_SDR) ? sr_out[0] : 1'b0;
    assign vji_uir   = (state == S_UIR);
    assign vji_cdr   = (state == S_CDR);
    assign vji_sdr   = (state == S_SDR);
    assign vji_udr   = (state == S_UDR);
    assign vji_rti   = (state == S_IDLE) || (state == S_RTI);

endmodule

// File: tb/tb_nios_debug_scan_master.sv
// Drives randomized scans into the engine against a loopback slave register and a timing/sequence model.
module tb_nios_debug_scan_master;
    localparam int DW = 38;
    localparam int IW = 2;
    localparam int TD = 2;
    localparam int RC = 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          cmd_valid, cmd_ready, rsp_valid, rsp_ready;
    logic [IW-1:0] cmd_ir, ir_in;
    logic [DW-1:0] cmd_data, rsp_data;
    logic          tck, tdi, tdo, uir, cdr, sdr, udr, rti;

    logic          cmd_valid_b, cmd_ready_b, rsp_valid_b, rsp_ready_b;
    logic [IW-1:0] cmd_ir_b, ir_in_b;
    logic [DW-1:0] cmd_data_b, rsp_data_b;
    logic          tck_b, tdi_b, uir_b, cdr_b, sdr_b, udr_b, rti_b;

    nios_debug_scan_master dut (
        .clk(clk), .reset(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_ir(cmd_ir), .cmd_data(cmd_data), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .vji_tck(tck), .vji_tdi(tdi), .vji_tdo(tdo), .vji_ir_in(ir_in),
        .vji_uir(uir), .vji_cdr(cdr), .vji_sdr(sdr), .vji_udr(udr), .vji_rti(rti)
    );

    nios_debug_scan_master #(.TCK_DIV(1), .RTI_CYCLES(3)) dut_b (
        .clk(clk), .reset(rst), .cmd_valid(cmd_valid_b), .cmd_ready(cmd_ready_b),
        .cmd_ir(cmd_ir_b), .cmd_data(cmd_data_b), .rsp_valid(rsp_valid_b), .rsp_ready(rsp_ready_b),
        .rsp_data(rsp_data_b), .vji_tck(tck_b), .vji_tdi(tdi_b), .vji_tdo(1'b1), .vji_ir_in(ir_in_b),
        .vji_uir(uir_b), .vji_cdr(cdr_b), .vji_sdr(sdr_b), .vji_udr(udr_b), .vji_rti(rti_b)
    );

    // Loopback slave: a DR register that shifts tdi in from the MSB on each tck rise during SDR.
    logic          slv_load = 1'b0;
    logic [DW-1:0] slv_init, slv, tdi_log;
    int            sdr_rises;
    always @(posedge tck or posedge slv_load) begin
        if (slv_load) begin
            slv       <= slv_init;
            tdi_log   <= '0;
            sdr_rises <= 0;
        end else if (sdr) begin
            slv       <= {tdi, slv[DW-1:1]};
            tdi_log   <= {tdi, tdi_log[DW-1:1]};
            sdr_rises <= sdr_rises + 1;
        end
    end
    assign tdo = slv[0];

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int scode();
        if (uir) return 1;
        if (cdr) return 2;
        if (sdr) return 3;
        if (udr) return 4;
        if (rti) return 5;
        return 0;
    endfunction

    task automatic load_slave(input logic [DW-1:0] v);
        slv_init = v;
        slv_load = 1'b1;
        #1 slv_load = 1'b0;
    endtask

    task automatic issue(input logic [IW-1:0] ir, input logic [DW-1:0] data);
        for (int i = 0; i < 50 && !cmd_ready; i++) @(negedge clk);
        check("ready_before_cmd", cmd_ready, 1'b1);
        cmd_ir    = ir;
        cmd_data  = data;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_ir    = ~ir;
        cmd_data  = ~data;
    endtask

    task automatic run_scan(input logic [IW-1:0] ir, input logic [DW-1:0] data,
                            input logic [DW-1:0] sv, input int hold);
        int run_code[$];
        int run_len[$];
        int exp_len[5];
        int prev, len, code, rsp_cycle, multi, ir_bad, unstable, seen_ready;
        logic [DW-1:0] held;
        exp_len = '{2*TD, 2*TD, 2*TD*DW, 2*TD, 2*TD*RC};
        load_slave(sv);
        rsp_ready = (hold == 0);
        issue(ir, data);
        prev = -1; len = 0; rsp_cycle = -1; multi = 0; ir_bad = 0;
        for (int c = 1; c < 400; c++) begin
            code = scode();
            if ((int'(uir) + int'(cdr) + int'(sdr) + int'(udr)) > 1) multi++;
            if (code != 0 && ir_in !== ir) ir_bad++;
            if (code == prev) len++;
            else begin
                if (prev != -1) begin run_code.push_back(prev); run_len.push_back(len); end
                prev = code;
                len  = 1;
            end
            if (rsp_valid) begin rsp_cycle = c; break; end
            @(negedge clk);
        end
        check("rsp_cycle", rsp_cycle, 1 + 2*TD*(3 + DW + RC));
        check("rsp_data", rsp_data, sv);
        check("sdr_tck_rises", sdr_rises, DW);
        check("tdi_sequence", tdi_log, data);
        check("strobe_overlap", multi, 0);
        check("ir_in_held", ir_bad, 0);
        check("strobe_runs", run_code.size(), 5);
        if (run_code.size() == 5)
            for (int i = 0; i < 5; i++)
                check($sformatf("run%0d", i), {run_code[i], run_len[i]}, {i + 1, exp_len[i]});
        if (hold > 0) begin
            held = rsp_data;
            unstable = 0;
            seen_ready = 0;
            cmd_valid = 1'b1;
            repeat (hold) begin
                @(negedge clk);
                if (rsp_data !== held || !rsp_valid) unstable++;
                if (cmd_ready) seen_ready++;
            end
            check("rsp_stable", unstable, 0);
            check("cmd_blocked", seen_ready, 0);
            cmd_valid = 1'b0;
            rsp_ready = 1'b1;
        end
        @(negedge clk);
        check("ready_after_rsp", {cmd_ready, rsp_valid}, 2'b10);
        check("ir_kept_idle", ir_in, ir);
        rsp_ready = 1'b0;
    endtask

    task automatic run_sweep(input logic [DW-1:0] data);
        int rsp_cycle;
        for (int i = 0; i < 50 && !cmd_ready_b; i++) @(negedge clk);
        rsp_ready_b = 1'b1;
        cmd_ir_b    = 2'b01;
        cmd_data_b  = data;
        cmd_valid_b = 1'b1;
        @(negedge clk);
        cmd_valid_b = 1'b0;
        rsp_cycle = -1;
        for (int c = 1; c < 300; c++) begin
            if (rsp_valid_b) begin rsp_cycle = c; break; end
            @(negedge clk);
        end
        check("sweep_rsp_cycle", rsp_cycle, 89);
        check("sweep_rsp_data", rsp_data_b, {DW{1'b1}});
        @(negedge clk);
        check("sweep_ready_after", {cmd_ready_b, rsp_valid_b, ir_in_b}, 4'b1001);
        rsp_ready_b = 1'b0;
    endtask

    initial begin
        int bad;
        logic [DW-1:0] rd, rs;
        rst = 1'b1;
        cmd_valid = 1'b0; rsp_ready = 1'b0; cmd_ir = '0; cmd_data = '0;
        cmd_valid_b = 1'b0; rsp_ready_b = 1'b0; cmd_ir_b = '0; cmd_data_b = '0;
        slv_init = '0;
        load_slave('0);
        repeat (5) @(negedge clk);
        check("ready_in_reset", cmd_ready, 1'b0);
        rst = 1'b0;
        #1;
        check("reset_ctrl", {cmd_ready, rsp_valid, tck, tdi, uir, cdr, sdr, udr, rti}, 9'b100000001);
        check("reset_data", {ir_in, rsp_data}, '0);
        @(negedge clk);

        run_scan(2'b10, 38'h2A_5A5A_5A5A, 38'h15_1234_5678, 0);
        run_scan(2'b01, 38'h3F_0F0F_F0F0, 38'h00_DEAD_BEEF, 20);

        // Reset pulse in the middle of the 10th SDR period.
        load_slave(38'h12_3456_789A);
        issue(2'b11, 38'h01_0203_0405);
        repeat (45) @(negedge clk);
        check("pre_reset_in_sdr", sdr, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("midreset_ctrl", {cmd_ready, rsp_valid, tck, sdr, rti}, 5'b10001);
        check("midreset_data", {ir_in, rsp_data}, '0);
        bad = 0;
        repeat (200) begin
            @(negedge clk);
            if (rsp_valid) bad++;
        end
        check("no_rsp_after_reset", bad, 0);
        run_scan(2'b11, 38'h01_0203_0405, 38'h12_3456_789A, 3);

        for (int k = 0; k < 4; k++) begin
            rd = DW'({$urandom(), $urandom()});
            rs = DW'({$urandom(), $urandom()});
            run_scan(IW'($urandom_range(0, 3)), rd, rs,
                     ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 25)) : 0);
        end

        run_sweep(DW'({$urandom(), $urandom()}));
        run_sweep('0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/nios_debug_scan_master.md
# nios_debug_scan_master

Host-side scan engine for the Nios II debug slave's virtual JTAG port: the initiator that drives the same `vji_*` signal set the CPU debug slave consumes. It generates `tck`, the IR value, the virtual-state strobes (UIR/CDR/SDR/UDR/RTI), and serial `tdi`, and captures `tdo`. The result is a 38-bit DR exchange per command. It sits between an on-chip or testbench command source and the debug slave's TCK-domain logic, replacing the sld hub for simulation and embedded self-debug.

## Interface
- DR_WIDTH, 38, data-register scan length in bits
- IR_WIDTH, 2, virtual IR width
- TCK_DIV, 2, tck half-period in clk cycles (≥1)
- RTI_CYCLES, 1, tck periods spent in run-test-idle after UDR (≥1)

- clk  in  1  system clock; all logic rising-edge
- reset  in  1  synchronous, active-high reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  engine idle, command accepted when valid&ready
- cmd_ir  in  IR_WIDTH  IR value for this scan
- cmd_data  in  DR_WIDTH  DR bits to shift out, LSB first
- rsp_valid  out  1  captured DR available
- rsp_ready  in  1  response consumed
- rsp_data  out  DR_WIDTH  bits captured from tdo, first captured bit in [0]
- vji_tck  out  1  generated scan clock
- vji_tdi  out  1  serial data to slave
- vji_tdo  in  1  serial data from slave
- vji_ir_in  out  IR_WIDTH  virtual IR value
- vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti  out  1 each  virtual state indications

## Operation
- States: IDLE, UIR, CDR, SDR, UDR, RTI, RSP.
- Each non-IDLE/RSP state lasts whole tck periods. A period is TCK_DIV clk cycles low followed by TCK_DIV clk cycles high.
- IDLE: cmd_ready=1, vji_rti=1, tck low. On accept, latch cmd_ir into vji_ir_in and cmd_data into shift register sr_out; clear capture register; go to UIR.
- UIR: vji_uir=1 for 1 period → CDR.
- CDR: vji_cdr=1 for 1 period → SDR.
- SDR: vji_sdr=1 for exactly DR_WIDTH periods.
  - vji_tdi=sr_out[0] throughout each period; sr_out shifts right on each tck falling edge.
  - vji_tdo is sampled on the clk cycle that raises tck and shifted into the capture register from the MSB (right shift). After DR_WIDTH samples, the first sample sits in bit 0.
- UDR: vji_udr=1 for 1 period → RTI.
- RTI: vji_rti=1 for RTI_CYCLES periods → RSP.
- RSP: rsp_valid=1 and rsp_data = capture register, both held stable until rsp_ready → IDLE.
- Exactly one strobe among uir/cdr/sdr/udr is high at any time; rti is high only in IDLE and RTI. vji_ir_in holds its value from UIR through RSP and keeps the last value in IDLE.
- cmd_valid is ignored outside IDLE. rsp_ready is ignored outside RSP.

## Timing
- Reset (any cycle, including mid-scan): next cycle state=IDLE. tck, tdi, uir, cdr, sdr, udr and rsp_valid are 0; vji_ir_in, rsp_data and the shift/capture registers are 0; vji_rti=1. cmd_ready=0 while reset is high and 1 on the first cycle after it drops. An in-flight command is discarded with no response.
- Accept at clk cycle 0. UIR starts at cycle 1 with tck low; tck first rises at cycle 1+TCK_DIV.
- Scan length is P = 3 + DR_WIDTH + RTI_CYCLES periods (42 with defaults). rsp_valid rises at cycle 1 + 2·TCK_DIV·P (169 with defaults).
- If rsp_ready is high when rsp_valid rises, the handshake completes that cycle, IDLE follows next cycle, and cmd_ready=1 then. Minimum command-to-command spacing is 2 + 2·TCK_DIV·P cycles.
- The slave samples strobes and tdi on tck rising edges. All vji outputs change only on clk edges where tck falls or stays low, never coincident with a tck rise.
- Counters: the period counter has width ≥ clog2(DR_WIDTH+1), and the phase counter counts to TCK_DIV-1. There is no wrap within a command.

## Test plan
- Reset: hold reset 5 cycles, then release. Required: all outputs at the reset values above; cmd_ready=1 on the first cycle after release.
- Basic scan, defaults: cmd_ir=2'b10, cmd_data=38'h2A_5A5A_5A5A, with a bench model loopback of tdo = a 38-bit slave register preloaded to 38'h15_1234_5678. Required:
  - exactly 38 tck rises while vji_sdr=1
  - tdi sequence matches cmd_data LSB first
  - rsp_data=38'h15_1234_5678
  - rsp_valid rises at cycle 169
  - vji_ir_in=2'b10 from UIR on
- Strobe ordering: check the uir → cdr → sdr → udr → rti order, each strobe held exactly 2·TCK_DIV clk cycles (sdr held 38 periods), and never two strobes high at once.
- Backpressure: hold rsp_ready low for 20 cycles after rsp_valid. Required: rsp_data stable; cmd_valid asserted meanwhile is not accepted; cmd_ready rises the cycle after rsp_ready goes high.
- Mid-scan reset: assert reset 1 cycle during the 10th SDR period. Required: next cycle IDLE with tck=0 and sdr=0; no rsp_valid ever for that command; a following command completes normally.
- Parameter sweep: TCK_DIV=1, RTI_CYCLES=3, tdo tied to 1. Required: rsp_data all ones; rsp_valid at cycle 1+2·44=89.
